decode_issue: RTL and testbench

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/decode_issue_scoreboard.sv | 43 ++++
 rtl/decode_issue.sv | 104 ++++++++++
 tb/tb_decode_issue.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared decode definitions for the integer pipeline.
// Instruction fields, opcode classes and register-file geometry.
package cpu_pkg;

  localparam int REG_N   = 16;
  localparam int IDX_W   = 4;
  localparam int INSTR_W = 16;
  localparam int OP_W    = 4;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 8;
  localparam int RA_HI = 7;
  localparam int RA_LO = 4;
  localparam int RB_HI = 3;
  localparam int RB_LO = 0;

  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_AND = 4'h2;
  localparam logic [OP_W-1:0] OP_OR  = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR = 4'h4;
  localparam logic [OP_W-1:0] OP_CMP = 4'hC;
  localparam logic [OP_W-1:0] OP_ST  = 4'hD;
  localparam logic [OP_W-1:0] OP_BR  = 4'hE;
  localparam logic [OP_W-1:0] OP_NOP = 4'hF;

  localparam logic [OP_W-1:0] WCLASS_BOUND = 4'hC;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [IDX_W-1:0] rd;
    logic [IDX_W-1:0] ra;
    logic [IDX_W-1:0] rb;
  } instr_t;

  function automatic logic writes_rd(input logic [OP_W-1:0] op);
    return op < WCLASS_BOUND;
  endfunction

endpackage

// File: rtl/decode_issue_scoreboard.sv
// Register busy scoreboard with one set port, one clear port
// and three per-index read ports.
module decode_issue_scoreboard
  import cpu_pkg::*;
#(
  parameter int REG_N = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] qa_idx,
  input  logic [IDX_W-1:0] qb_idx,
  input  logic [IDX_W-1:0] qd_idx,
  output logic             qa,
  output logic             qb,
  output logic             qd
);

  logic [REG_N-1:0] busy;
  logic [REG_N-1:0] set_mask;
  logic [REG_N-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  // set is applied after clear so a same-index collision stays busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= (busy & ~clr_mask) | set_mask;
  end

  assign qa = busy[qa_idx];
  assign qb = busy[qb_idx];
  assign qd = busy[qd_idx];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: holds one decoded instruction, checks the
// scoreboard, and hands captured operands to execute.
module decode_issue
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_N  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       in_instr,
  output logic              in_ready,
  output logic [3:0]        selRa,
  output logic [3:0]        selRb,
  input  logic [DATA_W-1:0] ra,
  input  logic [DATA_W-1:0] rb,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [3:0]        ex_op,
  output logic [3:0]        ex_rd,
  output logic              ex_wen,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  input  logic              wb_valid,
  input  logic [3:0]        wb_rd,
  output logic [15:0]       stall_cnt
);

  logic   d_valid;
  instr_t d_instr;
  logic   d_wen;
  logic   busy_a;
  logic   busy_b;
  logic   busy_d;
  logic   hazard;
  logic   issue_fire;

  assign d_wen      = writes_rd(d_instr.op);
  assign hazard     = d_valid &&
                      (busy_a || busy_b || (d_wen && busy_d));
  assign issue_fire = d_valid && !hazard &&
                      (!ex_valid || ex_ready);
  assign in_ready   = !d_valid || issue_fire;
  assign selRa      = d_instr.ra;
  assign selRb      = d_instr.rb;

  decode_issue_scoreboard #(
    .REG_N(REG_N)
  ) u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .set_en (issue_fire && d_wen),
    .set_idx(d_instr.rd),
    .clr_en (wb_valid),
    .clr_idx(wb_rd),
    .qa_idx (d_instr.ra),
    .qb_idx (d_instr.rb),
    .qd_idx (d_instr.rd),
    .qa     (busy_a),
    .qb     (busy_b),
    .qd     (busy_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_valid <= 1'b0;
      d_instr <= '0;
    end else if (in_valid && in_ready) begin
      d_valid <= 1'b1;
      d_instr <= instr_t'(in_instr);
    end else if (issue_fire) begin
      d_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_rd    <= '0;
      ex_wen   <= 1'b0;
      ex_a     <= '0;
      ex_b     <= '0;
    end else if (issue_fire) begin
      ex_valid <= 1'b1;
      ex_op    <= d_instr.op;
      ex_rd    <= d_instr.rd;
      ex_wen   <= d_wen;
      ex_a     <= ra;
      ex_b     <= rb;
    end else if (ex_valid && ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (hazard && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_decode_issue.sv
// Scenario bench for decode_issue: expected issues are queued when
// an instruction is driven and popped when execute takes it.
module tb_decode_issue;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic        wen;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic [3:0]  selRa;
  logic [3:0]  selRb;
  logic [15:0] rf_a;
  logic [15:0] rf_b;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_op;
  logic [3:0]  ex_rd;
  logic        ex_wen;
  logic [15:0] ex_a;
  logic [15:0] ex_b;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [15:0] stall_cnt;

  exp_t q[$];
  exp_t e;
  int   pass_cnt;
  int   total;
  int   exp_stall;

  decode_issue #(
    .DATA_W(16),
    .REG_N (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_instr (in_instr),
    .in_ready (in_ready),
    .selRa    (selRa),
    .selRb    (selRb),
    .ra       (rf_a),
    .rb       (rf_b),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_op    (ex_op),
    .ex_rd    (ex_rd),
    .ex_wen   (ex_wen),
    .ex_a     (ex_a),
    .ex_b     (ex_b),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .stall_cnt(stall_cnt)
  );

  function automatic logic [15:0] rf(input logic [3:0] i);
    return {i, ~i, i ^ 4'h5, 4'hA};
  endfunction

  assign rf_a = rf(selRa);
  assign rf_b = rf(selRb);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic [15:0] i);
    exp_t r;
    r.op  = i[15:12];
    r.rd  = i[11:8];
    r.wen = (i[15:12] < 4'hC);
    r.a   = rf(i[7:4]);
    r.b   = rf(i[3:0]);
    return r;
  endfunction

  function automatic exp_t got();
    return exp_t'({ex_op, ex_rd, ex_wen, ex_a, ex_b});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] i);
    in_valid = 1'b1;
    in_instr = i;
    q.push_back(mk(i));
  endtask

  task automatic wb(input logic [3:0] idx);
    wb_valid = 1'b1;
    wb_rd    = idx;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    total++;
    if (ex_valid !== 1'b0) $display("FAIL rst_ex_valid got=%b exp=0", ex_valid);
    else pass_cnt++;
    total++;
    if (got() !== exp_t'(0)) $display("FAIL rst_x got=%h exp=0", got());
    else pass_cnt++;
    total++;
    if (stall_cnt !== 16'd0) $display("FAIL rst_stall got=%h exp=0", stall_cnt);
    else pass_cnt++;
    rst = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    push(16'h0123);
    step();
    push(16'h0456);
    step();
    in_valid = 1'b0;
    e = q.size() != 0 ? q.pop_front() : '0;
    total++;
    if (ex_valid !== 1'b1 || got() !== e)
      $display("FAIL b2b_x0 got=%b/%h exp=1/%h", ex_valid, got(), e);
    else pass_cnt++;
    step();
    e = q.size() != 0 ? q.pop_front() : '0;
    total++;
    if (ex_valid !== 1'b1 || got() !== e)
      $display("FAIL b2b_x1 got=%b/%h exp=1/%h", ex_valid, got(), e);
    else pass_cnt++;
    step();
    total++;
    if (ex_valid !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", ex_valid);
    else pass_cnt++;
    total++;
    if (stall_cnt !== 16'(exp_stall))
      $display("FAIL b2b_stall got=%0d exp=%0d", stall_cnt, exp_stall);
    else pass_cnt++;
    wb(4'd1);
    wb(4'd4);
  endtask

  task automatic test_raw_stall();
    push(16'h0123);
    step();
    push(16'h1415);
    step();
    in_valid = 1'b0;
    e = q.size() != 0 ? q.pop_front() : '0;
    total++;
    if (ex_valid !== 1'b1 || got() !== e)
      $display("FAIL raw_x0 got=%b/%h exp=1/%h", ex_valid, got(), e);
    else pass_cnt++;
    total++;
    if (in_ready !== 1'b0) $display("FAIL raw_hold_ready got=%b exp=0", in_ready);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      step();
      exp_stall++;
      total++;
      if (stall_cnt !== 16'(exp_stall) || in_ready !== 1'b0 || ex_valid !== 1'b0)
        $display("FAIL raw_stall%0d got=%0d/%b/%b exp=%0d/0/0",
                 k, stall_cnt, in_ready, ex_valid, exp_stall);
      else pass_cnt++;
    end
    wb(4'd1);
    exp_stall++;
    total++;
    if (ex_valid !== 1'b0 || stall_cnt !== 16'(exp_stall))
      $display("FAIL raw_wb_same_cycle got=%b/%0d exp=0/%0d",
               ex_valid, stall_cnt, exp_stall);
    else pass_cnt++;
    step();
    e = q.size() != 0 ? q.pop_front() : '0;
    total++;
    if (ex_valid !== 1'b1 || got() !== e)
      $display("FAIL raw_issue got=%b/%h exp=1/%h", ex_valid, got(), e);
    else pass_cnt++;
    total++;
    if (stall_cnt !== 16'(exp_stall))
      $display("FAIL raw_stall_end got=%0d exp=%0d", stall_cnt, exp_stall);
    else pass_cnt++;
    wb(4'd4);
  endtask

  task automatic test_backpressure();
    ex_ready = 1'b0;
    push(16'h0123);
    step();
    push(16'h0456);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (ex_valid !== 1'b1 || got() !== q[0] || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/%h/0",
                 k, ex_valid, got(), in_ready, q[0]);
      else pass_cnt++;
      total++;
      if (selRa !== 4'd5 || selRb !== 4'd6)
        $display("FAIL bp_dslot%0d got=%h/%h exp=5/6", k, selRa, selRb);
      else pass_cnt++;
      if (k < 3) step();
    end
    ex_ready = 1'b1;
    e = q.size() != 0 ? q.pop_front() : '0;
    step();
    e = q.size() != 0 ? q.pop_front() : '0;
    total++;
    if (ex_valid !== 1'b1 || got() !== e)
      $display("FAIL bp_next got=%b/%h exp=1/%h", ex_valid, got(), e);
    else pass_cnt++;
    step();
    total++;
    if (ex_valid !== 1'b0 || stall_cnt !== 16'(exp_stall))
      $display("FAIL bp_drain got=%b/%0d exp=0/%0d", ex_valid, stall_cnt, exp_stall);
    else pass_cnt++;
    wb(4'd1);
    wb(4'd4);
  endtask

  task automatic test_wb_collide();
    push(16'h0712);
    step();
    wb_valid = 1'b1;
    wb_rd    = 4'd7;
    push(16'h0870);
    step();
    wb_valid = 1'b0;
    in_valid = 1'b0;
    e = q.size() != 0 ? q.pop_front() : '0;
    total++;
    if (ex_valid !== 1'b1 || got() !== e)
      $display("FAIL wbc_x0 got=%b/%h exp=1/%h", ex_valid, got(), e);
    else pass_cnt++;
    step();
    exp_stall++;
    total++;
    if (stall_cnt !== 16'(exp_stall) || ex_valid !== 1'b0)
      $display("FAIL wbc_busy_kept got=%0d/%b exp=%0d/0", stall_cnt, ex_valid, exp_stall);
    else pass_cnt++;
    wb(4'd7);
    exp_stall++;
    step();
    e = q.size() != 0 ? q.pop_front() : '0;
    total++;
    if (ex_valid !== 1'b1 || got() !== e)
      $display("FAIL wbc_issue got=%b/%h exp=1/%h", ex_valid, got(), e);
    else pass_cnt++;
    total++;
    if (stall_cnt !== 16'(exp_stall))
      $display("FAIL wbc_stall got=%0d exp=%0d", stall_cnt, exp_stall);
    else pass_cnt++;
    wb(4'd8);
  endtask

  task automatic test_nowrite();
    push(16'hC123);
    step();
    push(16'h1415);
    step();
    in_valid = 1'b0;
    total++;
    if (ex_wen !== 1'b0) $display("FAIL nw_wen got=%b exp=0", ex_wen);
    else pass_cnt++;
    e = q.size() != 0 ? q.pop_front() : '0;
    total++;
    if (ex_valid !== 1'b1 || got() !== e)
      $display("FAIL nw_x0 got=%b/%h exp=1/%h", ex_valid, got(), e);
    else pass_cnt++;
    step();
    e = q.size() != 0 ? q.pop_front() : '0;
    total++;
    if (ex_valid !== 1'b1 || got() !== e)
      $display("FAIL nw_reader got=%b/%h exp=1/%h", ex_valid, got(), e);
    else pass_cnt++;
    total++;
    if (stall_cnt !== 16'(exp_stall))
      $display("FAIL nw_no_stall got=%0d exp=%0d", stall_cnt, exp_stall);
    else pass_cnt++;
    wb(4'd4);
  endtask

  task automatic test_reset_mid();
    ex_ready = 1'b0;
    push(16'h0123);
    step();
    push(16'h0456);
    step();
    in_valid = 1'b0;
    total++;
    if (ex_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL rm_pre got=%b/%b exp=1/0", ex_valid, in_ready);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    q.delete();
    exp_stall = 0;
    total++;
    if (ex_valid !== 1'b0 || in_ready !== 1'b1 || got() !== exp_t'(0))
      $display("FAIL rm_async got=%b/%b/%h exp=0/1/0", ex_valid, in_ready, got());
    else pass_cnt++;
    total++;
    if (stall_cnt !== 16'd0 || selRa !== 4'd0 || selRb !== 4'd0)
      $display("FAIL rm_clear got=%0d/%h/%h exp=0/0/0", stall_cnt, selRa, selRb);
    else pass_cnt++;
    step();
    step();
    rst = 1'b1;
    ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (ex_valid !== 1'b0) $display("FAIL rm_idle%0d got=%b exp=0", k, ex_valid);
      else pass_cnt++;
    end
    push(16'h0213);
    step();
    in_valid = 1'b0;
    step();
    e = q.size() != 0 ? q.pop_front() : '0;
    total++;
    if (ex_valid !== 1'b1 || got() !== e || stall_cnt !== 16'd0)
      $display("FAIL rm_new got=%b/%h/%0d exp=1/%h/0", ex_valid, got(), stall_cnt, e);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total     = 0;
    exp_stall = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    ex_ready  = 1'b1;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    test_reset();
    test_back_to_back();
    test_raw_stall();
    test_backpressure();
    test_wb_collide();
    test_nowrite();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
